// File: rtl/pipe3_datapath.sv
// Three-stage (fetch / execute / writeback) datapath with W-to-E forwarding,
// external stall, single-bubble flush on a taken branch and valid tracking.
module pipe3_datapath #(
  parameter int unsigned XLEN     = 19,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_e,
  output logic            valid_e,
  input  logic [XLEN-1:0] immext_e,
  input  logic [1:0]      resultsrc,
  input  logic            pcsrc,
  input  logic            alusrc,
  input  logic            regwrite,
  input  logic            memwrite,
  input  logic [3:0]      alucontrol,
  input  logic            stall,
  output logic            zero,
  output logic [XLEN-1:0] aluresult,
  output logic [XLEN-1:0] writedata,
  output logic            memwrite_o,
  input  logic [XLEN-1:0] readdata
);
  localparam int unsigned NREG = 8;
  localparam int unsigned RW   = 3;
  localparam int unsigned SHW  = 5;
  localparam logic [XLEN-1:0] STEP   = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] PC_RST = XLEN'(RESET_PC);

  logic [XLEN-1:0] pc_e;
  logic [XLEN-1:0] rf [NREG];
  logic            valid_w;
  logic            regwrite_w;
  logic [RW-1:0]   rd_w;
  logic [XLEN-1:0] result_w;

  logic [RW-1:0]   rs1;
  logic [RW-1:0]   rs2;
  logic [RW-1:0]   rd;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic [XLEN-1:0] result_e;
  logic [XLEN-1:0] pcnext;
  logic            taken;

  assign rs1   = instr_e[10:8];
  assign rs2   = instr_e[13:11];
  assign rd    = instr_e[7:5];
  assign taken = pcsrc & valid_e;

  assign pcnext = taken ? (pc_e + immext_e) : (pc + STEP);

  // Fetch / execute boundary: stall freezes, taken branch squashes the fetched slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= PC_RST;
      instr_e <= '0;
      pc_e    <= '0;
      valid_e <= 1'b0;
    end else if (!stall) begin
      pc <= pcnext;
      if (taken) begin
        instr_e <= '0;
        valid_e <= 1'b0;
      end else begin
        instr_e <= instr;
        pc_e    <= pc;
        valid_e <= 1'b1;
      end
    end
  end

  // Operand read with bypass from the instruction currently in W.
  always_comb begin
    srca      = (rs1 == '0) ? '0 : rf[rs1];
    writedata = (rs2 == '0) ? '0 : rf[rs2];
    if (regwrite_w && valid_w && (rd_w == rs1) && (rs1 != '0)) srca = result_w;
    if (regwrite_w && valid_w && (rd_w == rs2) && (rs2 != '0)) writedata = result_w;
    srcb = alusrc ? immext_e : writedata;
  end

  // ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt (signed), 6 sll, 7 srl; others add.
  always_comb begin
    aluresult = srca + srcb;
    case (alucontrol)
      4'd1:    aluresult = srca - srcb;
      4'd2:    aluresult = srca & srcb;
      4'd3:    aluresult = srca | srcb;
      4'd4:    aluresult = srca ^ srcb;
      4'd5:    aluresult = XLEN'($signed(srca) < $signed(srcb));
      4'd6:    aluresult = srca << srcb[SHW-1:0];
      4'd7:    aluresult = srca >> srcb[SHW-1:0];
      default: aluresult = srca + srcb;
    endcase
  end

  assign zero       = (aluresult == '0);
  assign memwrite_o = memwrite & valid_e;

  always_comb begin
    result_e = aluresult;
    case (resultsrc)
      2'b01:   result_e = readdata;
      2'b10:   result_e = pc_e + STEP;
      default: result_e = aluresult;
    endcase
  end

  // Execute / writeback boundary: a stalled E instruction enters W as a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_w    <= 1'b0;
      regwrite_w <= 1'b0;
      rd_w       <= '0;
      result_w   <= '0;
    end else begin
      valid_w    <= valid_e & ~stall;
      regwrite_w <= regwrite & valid_e & ~stall;
      rd_w       <= rd;
      result_w   <= result_e;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else if (regwrite_w && (rd_w != '0)) begin
      rf[rd_w] <= result_w;
    end
  end
endmodule

// File: doc/pipe3_datapath.md
Name: pipe3_datapath

Overview:
- Three-stage pipelined successor to the single-cycle datapath: Fetch (F), Execute (E), Writeback (W).
- E covers register read, ALU, branch resolution and data-memory access.
- Generalised in width, PC step and reset vector.
- Adds W-to-E forwarding, an external stall, a one-cycle flush on taken branch, and valid tracking.
- The existing controller decodes instr_e; the existing immediate extender is fed from instr_e and returns immext_e.

Parameters:
- XLEN, 19, datapath/PC/instruction width (minimum 14).
- PC_STEP, 4, PC increment per sequential fetch.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- pc  out  XLEN  fetch address to instruction memory.
- instr  in  XLEN  instruction at pc; combinational return.
- instr_e  out  XLEN  instruction in E, to controller and immediate extender.
- valid_e  out  1  E holds a real instruction (not a bubble).
- immext_e  in  XLEN  extended immediate of instr_e.
- resultsrc  in  2  00 ALU result, 01 readdata, 10 pc_e+PC_STEP (11 treated as 00).
- pcsrc  in  1  E instruction redirects fetch to pc_e+immext_e.
- alusrc  in  1  srcb select: 0 register rs2, 1 immext_e.
- regwrite  in  1  E instruction writes rd.
- memwrite  in  1  E instruction stores.
- alucontrol  in  4  ALU operation (existing ALU encoding).
- stall  in  1  freeze F and E this cycle.
- zero  out  1  ALU zero flag for E.
- aluresult  out  XLEN  ALU result / data address.
- writedata  out  XLEN  forwarded rs2 value.
- memwrite_o  out  1  memwrite & valid_e.
- readdata  in  XLEN  data-memory read data; combinational with aluresult.

Behaviour:
- Field map of instr_e: rs1=[10:8], rs2=[13:11], rd=[7:5].
- Register file: 8 x XLEN. Combinational read. Written on the rising edge from W when regwrite_w and rd_w != 0. r0 always reads 0.
- Reset (reset=0, takes effect immediately, independent of clk):
  - pc=RESET_PC; instr_e=0, valid_e=0, pc_e=0.
  - W register cleared: valid_w=0, regwrite_w=0, result_w=0, rd_w=0.
  - All registers cleared to 0.
  - memwrite_o=0. Remaining combinational outputs follow from this cleared state.
- F stage:
  - pcnext = pc_e+immext_e if (pcsrc & valid_e), else pc+PC_STEP.
  - All adds are modulo 2^XLEN; wrap-around is silent.
- F/E register, per rising edge:
  - stall=1: hold pc, instr_e, pc_e, valid_e.
  - else if pcsrc & valid_e (taken branch): pc<=pcnext; instr_e<=0, valid_e<=0 (flush). Penalty is exactly 1 bubble.
  - else: pc<=pcnext, instr_e<=instr, pc_e<=pc, valid_e<=1.
- E stage:
  - srca = fwd(rs1), writedata = fwd(rs2).
  - fwd(r) = result_w when (regwrite_w & valid_w & rd_w==r & r!=0), otherwise regfile[r].
  - srcb = alusrc ? immext_e : writedata.
  - result_e is selected per resultsrc.
- E/W register, per rising edge:
  - valid_w <= valid_e & ~stall; regwrite_w <= regwrite & valid_e & ~stall; rd_w, result_w captured.
  - A stall therefore inserts a bubble into W, so a held E instruction commits exactly once.
- Latency: an instruction is in E one cycle after fetch and writes the register file at the end of its W cycle. A dependent next instruction receives the value via forwarding, with no stall.
- Simultaneous events:
  - stall with pcsrc: redirect deferred until the stall drops. The branch then takes effect once.
  - Bubbles never write the register file, never store, and never redirect.
  - memwrite_o stays asserted during a stall of a store (request held).
- Reset asserted mid-pipeline discards the F, E and W contents. No pending write occurs after reset rises.

Test Plan:
- Reset release, instructions to a nop stream -> pc sequence 0,4,8,12; valid_e=0 in cycle 1, then 1.
- addi r1=5; add r2=r1+r1 back-to-back -> second instruction's srca=srcb=5 via forwarding; r2=10 after its W cycle.
- Taken branch at pc=8 with immext_e=16 -> pc becomes 24; instruction fetched at 12 squashed (valid_e=0, no register write, memwrite_o=0).
- stall held 3 cycles on a store at pc=4 -> pc, instr_e constant; memwrite_o=1 throughout; W receives exactly one commit (or bubble for the store) after the stall.
- Write to r0 with value 0x7FFFF -> subsequent read of r0 returns 0; no forwarding from rd=0.
- XLEN=19, pc=0x7FFFC -> next pc wraps to 0x00000; reset pulsed mid-stream -> pc=RESET_PC immediately, pending W write suppressed.
